// File: rtl/instr_sequencer_pkg.sv
// Definitions shared by the instruction sequencer and the execute stage:
// FSM state encoding, the halt opcode and the instruction-word field layout.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        UPDATE,
        HALT
    } seq_state_e;

    localparam logic [3:0]  HLT_OP_DEFAULT = 4'hF;

    localparam int unsigned IR_W    = 16;
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned OPR_MSB = 11;
    localparam int unsigned OPR_LSB = 0;

    function automatic logic [3:0] ir_opcode(input logic [IR_W-1:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [11:0] ir_operand(input logic [IR_W-1:0] ir);
        return ir[OPR_MSB:OPR_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer_pc.sv
// Program counter register: load has priority over increment; the increment
// wraps silently modulo 2^ADDR_W.
module program_counter #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Four-stage instruction sequencer (fetch/decode/execute/update) with an
// instruction register and a terminal HALT state left only through reset.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter logic [3:0]  HLT_OP = HLT_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [15:0]       mem_data,
    output logic [3:0]        opcode,
    output logic [11:0]       operand,
    output logic              op_valid,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    seq_state_e        state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic              br_taken_q, br_taken_d;
    logic [ADDR_W-1:0] br_target_q, br_target_d;
    logic              pc_inc, pc_load;

    program_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk        (clk),
        .rst        (reset),
        .inc_i      (pc_inc),
        .load_i     (pc_load),
        .load_val_i (br_target_q),
        .pc_o       (pc)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = (ir_opcode(ir_q) == HLT_OP) ? HALT : EXECUTE;
            end
            EXECUTE: begin
                if (exec_done) begin
                    br_taken_d  = branch_taken;
                    br_target_d = branch_target;
                    state_d     = UPDATE;
                end
            end
            UPDATE: begin
                pc_load = br_taken_q;
                pc_inc  = ~br_taken_q;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            ir_q        <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    // Reset already forces FETCH; gating keeps the fetch request low while it is held.
    assign mem_rd   = (state_q == FETCH) && !reset;
    assign mem_addr = pc;
    assign op_valid = (state_q == EXECUTE);
    assign halted   = (state_q == HALT);
    assign opcode   = ir_opcode(ir_q);
    assign operand  = ir_operand(ir_q);

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-counter and memory-address width.
REQ-002 SHALL have parameter HLT_OP, default 4'hF, opcode that halts the sequencer.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_addr  output  ADDR_W  instruction fetch address.
REQ-006 SHALL have port mem_rd  output  1  fetch request.
REQ-007 SHALL have port mem_ready  input  1  fetch data valid this cycle.
REQ-008 SHALL have port mem_data  input  16  fetched instruction word.
REQ-009 SHALL have port opcode  output  4  instruction bits [15:12], driven to the 4-to-16 opcode decoder.
REQ-010 SHALL have port operand  output  12  instruction bits [11:0].
REQ-011 SHALL have port op_valid  output  1  opcode/operand valid for the execute stage.
REQ-012 SHALL have port exec_done  input  1  execute stage has completed the current instruction.
REQ-013 SHALL have port branch_taken  input  1  redirect the PC; qualified by exec_done.
REQ-014 SHALL have port branch_target  input  ADDR_W  redirect address.
REQ-015 SHALL have port pc  output  ADDR_W  current program counter.
REQ-016 SHALL have port halted  output  1  sequencer is in HALT.

Function
REQ-017 SHALL implement FSM states FETCH, DECODE, EXECUTE, UPDATE, HALT.
REQ-018 FETCH: mem_rd=1, mem_addr=pc; on mem_ready=1, latch mem_data into the instruction register (IR) and go to DECODE; otherwise stay in FETCH.
REQ-019 DECODE: one cycle; opcode=IR[15:12] and operand=IR[11:0] valid; go to HALT if opcode==HLT_OP, else go to EXECUTE.
REQ-020 EXECUTE: op_valid=1; exec_done is sampled every cycle, including the first; on exec_done=1, capture branch_taken and branch_target and go to UPDATE.
REQ-021 UPDATE: one cycle; pc <= captured branch_target if captured branch_taken, else pc+1; then go to FETCH.
REQ-022 pc+1 SHALL wrap modulo 2^ADDR_W (all-ones -> 0) with no flag.
REQ-023 HALT: halted=1, mem_rd=0, op_valid=0; pc and IR hold; exit only by reset.
REQ-024 opcode/operand SHALL remain stable from DECODE through UPDATE and change only when IR is reloaded.
REQ-025 mem_ready outside FETCH and exec_done/branch_taken outside EXECUTE SHALL be ignored.
REQ-026 mem_rd SHALL be 0 outside FETCH; op_valid SHALL be 0 outside EXECUTE.
REQ-027 Minimum latency, with mem_ready and exec_done immediately high, SHALL be 4 cycles per instruction.
REQ-028 branch_taken=1 with exec_done=0 SHALL have no effect.

Reset
REQ-029 Asserting reset SHALL immediately force state=FETCH, pc=0, IR=0, and therefore opcode=0, operand=0, op_valid=0, halted=0.
REQ-030 While reset is asserted, mem_rd SHALL be 0.
REQ-031 Reset asserted mid-fetch or mid-execute SHALL abort the instruction with no PC update.
REQ-032 The first fetch after reset deassertion SHALL be from address 0.

Structure
REQ-033 State encoding, HLT_OP, and the IR field positions (opcode [15:12], operand [11:0]) SHALL reside in a shared package/include used by the sequencer and the execute stage.
REQ-034 The PC register with increment/load/wrap SHALL be a sub-module named program_counter; the FSM and IR SHALL reside in instr_sequencer.

Verification
REQ-035 Program 0x1123, 0x2456 at addresses 0-1, with mem_ready and exec_done tied high -> opcode 1 then 2, op_valid pulses spaced 4 cycles, pc=2 after the second UPDATE.
REQ-036 mem_ready held low for 3 cycles in FETCH -> mem_rd stays high, mem_addr is stable, and DECODE is entered the cycle after mem_ready rises.
REQ-037 exec_done with branch_taken=1 and branch_target=0x40 -> next mem_addr=0x40; branch_taken=1 with exec_done=0 -> no redirect.
REQ-038 pc=0xFF, non-branch instruction -> next fetch from 0x00.
REQ-039 Instruction 0xF000 -> halted=1 after DECODE, mem_rd=0 thereafter; reset -> fetch from 0, halted=0.
REQ-040 Reset asserted during EXECUTE with pc=0x10 -> op_valid=0 and pc=0 immediately, with no UPDATE.
